// File: rtl/busca_pkg.sv
// Shared types for the instruction-fetch stage and the addressing-mode decoder.
// FSM states, addressing-mode codes and opcode classes.
package busca_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      BUSCA   = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   localparam logic [1:0] MODO_I  = 2'b00;
   localparam logic [1:0] MODO_J  = 2'b01;
   localparam logic [1:0] MODO_R  = 2'b10;
   localparam logic [1:0] MODO_JE = 2'b11;

   // opcode[4:3] classes
   localparam logic [1:0] CLASSE_R  = 2'b00;
   localparam logic [1:0] CLASSE_I  = 2'b01;
   localparam logic [1:0] CLASSE_J  = 2'b10;
   localparam logic [1:0] CLASSE_JE = 2'b11;

   localparam int unsigned OPC_W   = 5;
   localparam int unsigned INSTR_W = 27;

endpackage

// File: rtl/busca_instrucao_if.sv
// Bundles of the fetch stage: instruction-memory bus and downstream output.
// Signal names match the fetch-stage port names.
interface busca_mem_if #(
   parameter int PC_W = 10
) ();
   logic            mem_req;
   logic [PC_W-1:0] mem_addr;
   logic            mem_ack;
   logic [31:0]     mem_dado;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_dado
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_dado
   );
endinterface

interface busca_saida_if #(
   parameter int PC_W = 10
) ();
   logic            saida_valida;
   logic            saida_pronta;
   logic [4:0]      opcode;
   logic [26:0]     instrucao;
   logic [1:0]      controle;
   logic [PC_W-1:0] pc_atual;

   modport master (
      output saida_valida,
      input  saida_pronta,
      output opcode,
      output instrucao,
      output controle,
      output pc_atual
   );

   modport slave (
      input  saida_valida,
      output saida_pronta,
      input  opcode,
      input  instrucao,
      input  controle,
      input  pc_atual
   );
endinterface

// File: rtl/busca_instrucao_classe_opcode.sv
// Combinational opcode -> addressing-mode (controle) mapping.
// Shared with the addressing-mode decoder.
module classe_opcode
   import busca_pkg::*;
(
   input  logic [4:0] opcode,
   output logic [1:0] controle
);

   logic [1:0] classe;
   logic       unused_bits;

   assign classe      = opcode[4:3];
   assign unused_bits = ^opcode[2:0];

   always_comb begin
      controle = MODO_R;
      unique case (1'b1)
         (classe == CLASSE_R):  controle = MODO_R;
         (classe == CLASSE_I):  controle = MODO_I;
         (classe == CLASSE_J):  controle = MODO_J;
         (classe == CLASSE_JE): controle = MODO_JE;
      endcase
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: PC, memory req/ack, latched word, valid/ready out.
// Optional BUSCA_CONTADORES_EN adds delivered/discarded word counters.
module busca_instrucao
   import busca_pkg::*;
#(
   parameter int              PC_W       = 10,
   parameter logic [PC_W-1:0] PC_INICIAL = '0
) (
   input  logic            clock,
   input  logic            reset_n,
   busca_mem_if.master     mem,
   input  logic            desvio,
   input  logic [PC_W-1:0] endereco_desvio,
   busca_saida_if.master   saida
`ifdef BUSCA_CONTADORES_EN
   ,
   output logic [15:0]     cont_entregues,
   output logic [15:0]     cont_descartes
`endif
);

   estado_t         estado_q, estado_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] addr_q, addr_d;
   logic [PC_W-1:0] pca_q, pca_d;
   logic            desc_q, desc_d;
   logic [31:0]     palavra_q, palavra_d;
   logic [1:0]      ctrl_q, ctrl_d;
   logic [1:0]      ctrl_nova;
   logic [PC_W-1:0] pc_inc;

   classe_opcode u_classe (
      .opcode   (mem.mem_dado[31:27]),
      .controle (ctrl_nova)
   );

   assign pc_inc = pc_q + PC_W'(1);

   always_comb begin
      estado_d  = estado_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      pca_d     = pca_q;
      desc_d    = desc_q;
      palavra_d = palavra_q;
      ctrl_d    = ctrl_q;
      case (estado_q)
         OCIOSO: begin
            if (desvio) begin
               pc_d = endereco_desvio;
            end else begin
               addr_d   = pc_q;
               estado_d = BUSCA;
            end
         end
         BUSCA: begin
            // redirect never aborts the bus transfer; the word is dropped later
            if (desvio) begin
               pc_d   = endereco_desvio;
               desc_d = 1'b1;
            end
            if (mem.mem_ack) begin
               if (desvio || desc_q) begin
                  desc_d   = 1'b0;
                  estado_d = OCIOSO;
               end else begin
                  palavra_d = mem.mem_dado;
                  ctrl_d    = ctrl_nova;
                  pca_d     = addr_q;
                  estado_d  = ENTREGA;
               end
            end
         end
         ENTREGA: begin
            if (desvio) begin
               pc_d     = endereco_desvio;
               addr_d   = endereco_desvio;
               estado_d = BUSCA;
            end else if (saida.saida_pronta) begin
               pc_d     = pc_inc;
               addr_d   = pc_inc;
               estado_d = BUSCA;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q  <= OCIOSO;
         pc_q      <= PC_INICIAL;
         addr_q    <= PC_INICIAL;
         pca_q     <= PC_INICIAL;
         desc_q    <= 1'b0;
         palavra_q <= '0;
         ctrl_q    <= '0;
      end else begin
         estado_q  <= estado_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         pca_q     <= pca_d;
         desc_q    <= desc_d;
         palavra_q <= palavra_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign mem.mem_req        = (estado_q == BUSCA);
   assign mem.mem_addr       = addr_q;
   assign saida.saida_valida = (estado_q == ENTREGA);
   assign saida.opcode       = palavra_q[31:27];
   assign saida.instrucao    = palavra_q[26:0];
   assign saida.controle     = ctrl_q;
   assign saida.pc_atual     = pca_q;

`ifdef BUSCA_CONTADORES_EN
   logic        entregue, descartada;
   logic [15:0] cont_ent_q, cont_ent_d;
   logic [15:0] cont_desc_q, cont_desc_d;

   assign entregue   = (estado_q == ENTREGA) && saida.saida_pronta;
   assign descartada = (estado_q == BUSCA) && mem.mem_ack
                       && (desvio || desc_q);

   always_comb begin
      cont_ent_d  = cont_ent_q;
      cont_desc_d = cont_desc_q;
      if (entregue && (cont_ent_q != 16'hFFFF)) begin
         cont_ent_d = cont_ent_q + 16'd1;
      end
      if (descartada && (cont_desc_q != 16'hFFFF)) begin
         cont_desc_d = cont_desc_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cont_ent_q  <= '0;
         cont_desc_q <= '0;
      end else begin
         cont_ent_q  <= cont_ent_d;
         cont_desc_q <= cont_desc_d;
      end
   end

   assign cont_entregues = cont_ent_q;
   assign cont_descartes = cont_desc_q;
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed, table-driven bench for the busca_instrucao fetch stage.
// Optional counter checks when BUSCA_CONTADORES_EN is defined.
module tb_busca_instrucao;

   localparam int PC_W = 10;

   typedef struct {
      logic [31:0] dado;
      logic [4:0]  opc;
      logic [26:0] instr;
      logic [1:0]  ctrl;
   } vetor_t;

   logic            clock;
   logic            reset_n;
   logic            desvio;
   logic [PC_W-1:0] endereco_desvio;
`ifdef BUSCA_CONTADORES_EN
   logic [15:0]     cont_entregues;
   logic [15:0]     cont_descartes;
`endif

   busca_mem_if   #(.PC_W(PC_W)) mem_if ();
   busca_saida_if #(.PC_W(PC_W)) sai_if ();

   busca_instrucao #(
      .PC_W       (PC_W),
      .PC_INICIAL ('0)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .mem             (mem_if),
      .desvio          (desvio),
      .endereco_desvio (endereco_desvio),
      .saida           (sai_if)
`ifdef BUSCA_CONTADORES_EN
      ,
      .cont_entregues  (cont_entregues),
      .cont_descartes  (cont_descartes)
`endif
   );

   int n_chk;
   int n_err;
   int n_ent;
   int n_desc;
   vetor_t tbl [7];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nome, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nome, got, exp);
      end
   endtask

   task automatic ack_com(input logic [31:0] d);
      mem_if.mem_ack  = 1'b1;
      mem_if.mem_dado = d;
      step();
      mem_if.mem_ack  = 1'b0;
      mem_if.mem_dado = '0;
   endtask

   task automatic entrega();
      sai_if.saida_pronta = 1'b1;
      step();
      sai_if.saida_pronta = 1'b0;
      n_ent++;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      n_ent = 0;
      n_desc = 0;
      reset_n = 1'b0;
      desvio = 1'b0;
      endereco_desvio = '0;
      mem_if.mem_ack = 1'b0;
      mem_if.mem_dado = '0;
      sai_if.saida_pronta = 1'b0;

      tbl[0] = '{32'h1000_0000, 5'd2,  27'h000_0000, 2'b10};
      tbl[1] = '{32'h4ABC_DEF1, 5'd9,  27'h2BC_DEF1, 2'b00};
      tbl[2] = '{32'h8000_0001, 5'd16, 27'h000_0001, 2'b01};
      tbl[3] = '{32'hFFFF_FFFF, 5'd31, 27'h7FF_FFFF, 2'b11};
      tbl[4] = '{32'h07FF_FFFF, 5'd0,  27'h7FF_FFFF, 2'b10};
      tbl[5] = '{32'hC800_0123, 5'd25, 27'h000_0123, 2'b11};
      tbl[6] = '{32'h5800_0000, 5'd11, 27'h000_0000, 2'b00};

      repeat (2) step();
      chk("rst_req",   32'(mem_if.mem_req), 0);
      chk("rst_valid", 32'(sai_if.saida_valida), 0);
      chk("rst_addr",  32'(mem_if.mem_addr), 0);
      chk("rst_pc",    32'(sai_if.pc_atual), 0);
      chk("rst_opc",   32'(sai_if.opcode), 0);
      chk("rst_instr", 32'(sai_if.instrucao), 0);
      chk("rst_ctrl",  32'(sai_if.controle), 0);

      reset_n = 1'b1;
      step();
      chk("first_req",   32'(mem_if.mem_req), 1);
      chk("first_addr",  32'(mem_if.mem_addr), 0);
      chk("first_valid", 32'(sai_if.saida_valida), 0);

      ack_com(32'h1000_0000);
      chk("zw_valid", 32'(sai_if.saida_valida), 1);
      chk("zw_opc",   32'(sai_if.opcode), 2);
      chk("zw_instr", 32'(sai_if.instrucao), 0);
      chk("zw_ctrl",  32'(sai_if.controle), 2);
      chk("zw_pc",    32'(sai_if.pc_atual), 0);
      chk("zw_req",   32'(mem_if.mem_req), 0);
      entrega();
      chk("hs_req",   32'(mem_if.mem_req), 1);
      chk("hs_addr",  32'(mem_if.mem_addr), 1);
      chk("hs_valid", 32'(sai_if.saida_valida), 0);

      // ack held off 3 cycles: address and request must not move
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wait_addr", 32'(mem_if.mem_addr), 1);
         chk("wait_req",  32'(mem_if.mem_req), 1);
      end
      ack_com(32'h4ABC_DEF1);
      mem_if.mem_ack  = 1'b1;
      mem_if.mem_dado = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         chk("frz_valid", 32'(sai_if.saida_valida), 1);
         chk("frz_opc",   32'(sai_if.opcode), 9);
         chk("frz_instr", 32'(sai_if.instrucao), 32'h2BC_DEF1);
         chk("frz_ctrl",  32'(sai_if.controle), 0);
         chk("frz_pc",    32'(sai_if.pc_atual), 1);
         step();
      end
      mem_if.mem_ack  = 1'b0;
      mem_if.mem_dado = '0;
      entrega();
      chk("next_addr", 32'(mem_if.mem_addr), 2);
      chk("next_req",  32'(mem_if.mem_req), 1);

      for (int i = 0; i < 7; i++) begin
         ack_com(tbl[i].dado);
         chk("tbl_valid", 32'(sai_if.saida_valida), 1);
         chk("tbl_opc",   32'(sai_if.opcode), 32'(tbl[i].opc));
         chk("tbl_instr", 32'(sai_if.instrucao), 32'(tbl[i].instr));
         chk("tbl_ctrl",  32'(sai_if.controle), 32'(tbl[i].ctrl));
         chk("tbl_pc",    32'(sai_if.pc_atual), 32'(2 + i));
         entrega();
         chk("tbl_addr",  32'(mem_if.mem_addr), 32'(3 + i));
      end

      // redirect during BUSCA, ack two cycles later
      desvio = 1'b1;
      endereco_desvio = 10'h155;
      step();
      desvio = 1'b0;
      chk("dv_addr0", 32'(mem_if.mem_addr), 9);
      chk("dv_req0",  32'(mem_if.mem_req), 1);
      step();
      chk("dv_addr1", 32'(mem_if.mem_addr), 9);
      ack_com(32'hFFFF_FFFF);
      n_desc++;
      chk("dv_valid", 32'(sai_if.saida_valida), 0);
      chk("dv_idle",  32'(mem_if.mem_req), 0);
      chk("dv_keep",  32'(sai_if.opcode), 11);
      step();
      chk("dv_req",   32'(mem_if.mem_req), 1);
      chk("dv_tgt",   32'(mem_if.mem_addr), 32'h155);

      // redirect together with ack, then redirect while idle
      desvio = 1'b1;
      endereco_desvio = 10'h0AA;
      ack_com(32'h8000_0001);
      n_desc++;
      chk("dva_valid", 32'(sai_if.saida_valida), 0);
      chk("dva_idle",  32'(mem_if.mem_req), 0);
      endereco_desvio = 10'h3FF;
      step();
      desvio = 1'b0;
      chk("dvo_idle", 32'(mem_if.mem_req), 0);
      step();
      chk("dvo_req",  32'(mem_if.mem_req), 1);
      chk("dvo_addr", 32'(mem_if.mem_addr), 32'h3FF);

      ack_com(32'h8000_0001);
      chk("wr_valid", 32'(sai_if.saida_valida), 1);
      chk("wr_pc",    32'(sai_if.pc_atual), 32'h3FF);
      chk("wr_ctrl",  32'(sai_if.controle), 1);
      entrega();
      chk("wr_addr",  32'(mem_if.mem_addr), 0);
      chk("wr_req",   32'(mem_if.mem_req), 1);

      // redirect in ENTREGA with and without pronta
      ack_com(32'hC800_0123);
      chk("de_pc", 32'(sai_if.pc_atual), 0);
      desvio = 1'b1;
      endereco_desvio = 10'h200;
      entrega();
      desvio = 1'b0;
      chk("de_valid", 32'(sai_if.saida_valida), 0);
      chk("de_req",   32'(mem_if.mem_req), 1);
      chk("de_addr",  32'(mem_if.mem_addr), 32'h200);
      ack_com(32'h1000_0000);
      desvio = 1'b1;
      endereco_desvio = 10'h123;
      step();
      desvio = 1'b0;
      chk("dn_valid", 32'(sai_if.saida_valida), 0);
      chk("dn_addr",  32'(mem_if.mem_addr), 32'h123);

`ifdef BUSCA_CONTADORES_EN
      chk("cnt_ent",  32'(cont_entregues), 32'(n_ent));
      chk("cnt_desc", 32'(cont_descartes), 32'(n_desc));
      force dut.cont_ent_q = 16'hFFFF;
      step();
      release dut.cont_ent_q;
      ack_com(32'h1000_0000);
      entrega();
      chk("cnt_sat",  32'(cont_entregues), 32'hFFFF);
`endif

      // asynchronous reset in the middle of a transfer
      chk("mid_req", 32'(mem_if.mem_req), 1);
      reset_n = 1'b0;
      #1;
      chk("ar_req",   32'(mem_if.mem_req), 0);
      chk("ar_addr",  32'(mem_if.mem_addr), 0);
      chk("ar_valid", 32'(sai_if.saida_valida), 0);
      chk("ar_pc",    32'(sai_if.pc_atual), 0);
      chk("ar_opc",   32'(sai_if.opcode), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
